// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative, write-back, write-allocate data cache.
// Serves byte/word loads and stores with a registered response one cycle after
// accept on a hit. Misses block in an evict/fill/replay sequence over a
// line-wide memory port. Optional misaligned-word rejection is enabled by
// defining DCACHE_ALIGN_CHECK_EN.
module dcache_assoc #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned NUM_SETS   = 4,
  parameter int unsigned NUM_WAYS   = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  req_ready,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_is_store,
  input  logic                  req_size,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  xcpt_addr_fault,
  output logic                  mem_req_valid,
  output logic                  mem_req_is_store,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_data,
  input  logic                  mem_rsp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data
);

  localparam int unsigned OFF   = $clog2(LINE_WIDTH / 8);
  localparam int unsigned IDX   = $clog2(NUM_SETS);
  localparam int unsigned TAG   = ADDR_WIDTH - OFF - IDX;
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StEvict, StFill, StReplay} state_e;

  state_e state_q, state_d;

  logic [LINE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_WIDTH-1:0] data_d  [NUM_SETS][NUM_WAYS];
  logic [TAG-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG-1:0]        tag_d   [NUM_SETS][NUM_WAYS];
  logic                  valid_q [NUM_SETS][NUM_WAYS];
  logic                  valid_d [NUM_SETS][NUM_WAYS];
  logic                  dirty_q [NUM_SETS][NUM_WAYS];
  logic                  dirty_d [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]      ptr_q   [NUM_SETS];
  logic [WAY_W-1:0]      ptr_d   [NUM_SETS];

  // Latched miss request and chosen victim way
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic                  lat_store_q, lat_store_d;
  logic                  lat_size_q, lat_size_d;
  logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [WAY_W-1:0]      vic_q, vic_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  xcpt_q, xcpt_d;

  // Lookup path: the live request in IDLE, the latched one in REPLAY
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_store;
  logic                  acc_size;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [IDX-1:0]        acc_idx;
  logic [TAG-1:0]        acc_tag;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic [WAY_W-1:0]      vic_way;
  logic [LINE_WIDTH-1:0] hit_line;
  logic [LINE_WIDTH-1:0] wr_line;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [DATA_WIDTH-1:0] load_data;
  logic [IDX-1:0]        lat_idx;
  logic [TAG-1:0]        lat_tag;
  logic                  misaligned;

`ifdef DCACHE_ALIGN_CHECK_EN
  assign misaligned = req_size & (req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign lat_idx = lat_addr_q[OFF+IDX-1:OFF];
  assign lat_tag = lat_addr_q[ADDR_WIDTH-1:OFF+IDX];

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign xcpt_addr_fault = xcpt_q;

  // Tag compare, victim choice, load extract and store merge for the access
  always_comb begin
    acc_addr  = (state_q == StReplay) ? lat_addr_q  : req_addr;
    acc_store = (state_q == StReplay) ? lat_store_q : req_is_store;
    acc_size  = (state_q == StReplay) ? lat_size_q  : req_size;
    acc_data  = (state_q == StReplay) ? lat_data_q  : req_data;
    acc_idx   = acc_addr[OFF+IDX-1:OFF];
    acc_tag   = acc_addr[ADDR_WIDTH-1:OFF+IDX];

    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (valid_q[acc_idx][w] && (tag_q[acc_idx][w] == acc_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end

    // Lowest invalid way wins; otherwise the round-robin pointer
    vic_way = ptr_q[acc_idx];
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[acc_idx][w]) begin
        vic_way = WAY_W'(w);
      end
    end

    hit_line = data_q[acc_idx][hit_way];
    rd_word  = hit_line[{acc_addr[OFF-1:2], 5'b0} +: 32];
    rd_byte  = hit_line[{acc_addr[OFF-1:0], 3'b0} +: 8];
    load_data = acc_size ? DATA_WIDTH'(rd_word) : DATA_WIDTH'(rd_byte);

    wr_line = hit_line;
    if (acc_size) begin
      wr_line[{acc_addr[OFF-1:2], 5'b0} +: 32] = acc_data[31:0];
    end else begin
      wr_line[{acc_addr[OFF-1:0], 3'b0} +: 8] = acc_data[7:0];
    end
  end

  // Miss FSM next state, array updates and memory/request-side outputs
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    ptr_d       = ptr_q;
    lat_addr_d  = lat_addr_q;
    lat_store_d = lat_store_q;
    lat_size_d  = lat_size_q;
    lat_data_d  = lat_data_q;
    vic_d       = vic_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    xcpt_d      = 1'b0;

    req_ready        = 1'b0;
    mem_req_valid    = 1'b0;
    mem_req_is_store = 1'b0;
    mem_req_addr     = '0;
    mem_req_data     = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned) begin
            xcpt_d = 1'b1;
          end else if (hit) begin
            rsp_valid_d = 1'b1;
            if (acc_store) begin
              data_d[acc_idx][hit_way]  = wr_line;
              dirty_d[acc_idx][hit_way] = 1'b1;
            end else begin
              rsp_data_d = load_data;
            end
          end else begin
            lat_addr_d  = req_addr;
            lat_store_d = req_is_store;
            lat_size_d  = req_size;
            lat_data_d  = req_data;
            vic_d       = vic_way;
            if (valid_q[acc_idx][vic_way] && dirty_q[acc_idx][vic_way]) begin
              state_d = StEvict;
            end else begin
              state_d = StFill;
            end
          end
        end
      end

      StEvict: begin
        mem_req_valid    = 1'b1;
        mem_req_is_store = 1'b1;
        mem_req_addr     = {tag_q[lat_idx][vic_q], lat_idx, {OFF{1'b0}}};
        mem_req_data     = data_q[lat_idx][vic_q];
        if (mem_rsp_valid) begin
          state_d = StFill;
        end
      end

      StFill: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {lat_tag, lat_idx, {OFF{1'b0}}};
        if (mem_rsp_valid) begin
          data_d[lat_idx][vic_q]  = mem_rsp_data;
          tag_d[lat_idx][vic_q]   = lat_tag;
          valid_d[lat_idx][vic_q] = 1'b1;
          dirty_d[lat_idx][vic_q] = 1'b0;
          ptr_d[lat_idx] = (ptr_q[lat_idx] == WAY_W'(NUM_WAYS - 1)) ? '0
                                                                     : ptr_q[lat_idx] + WAY_W'(1);
          state_d = StReplay;
        end
      end

      StReplay: begin
        // The line was just filled, so the lookup hits in vic_q
        rsp_valid_d = 1'b1;
        if (acc_store) begin
          data_d[acc_idx][hit_way]  = wr_line;
          dirty_d[acc_idx][hit_way] = 1'b1;
        end else begin
          rsp_data_d = load_data;
        end
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // Control state with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
        ptr_q[s] <= '0;
      end
      lat_addr_q  <= '0;
      lat_store_q <= 1'b0;
      lat_size_q  <= 1'b0;
      lat_data_q  <= '0;
      vic_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      xcpt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      ptr_q       <= ptr_d;
      lat_addr_q  <= lat_addr_d;
      lat_store_q <= lat_store_d;
      lat_size_q  <= lat_size_d;
      lat_data_q  <= lat_data_d;
      vic_q       <= vic_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      xcpt_q      <= xcpt_d;
    end
  end

  // Data and tag storage; contents are qualified by valid, so no reset
  always_ff @(posedge clock) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Self-checking bench for dcache_assoc (default parameters). Loads are checked
// against an architectural byte-accurate memory image; write-backs are checked
// against the same image, and fills are served from a backing memory.
module tb_dcache_assoc;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_ready;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_is_store = 1'b0;
  logic         req_size = 1'b0;
  logic [31:0]  req_data = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         xcpt_addr_fault;
  logic         mem_req_valid;
  logic         mem_req_is_store;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;

  dcache_assoc dut (
    .clock            (clock),
    .reset            (reset),
    .req_ready        (req_ready),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_is_store     (req_is_store),
    .req_size         (req_size),
    .req_data         (req_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .xcpt_addr_fault  (xcpt_addr_fault),
    .mem_req_valid    (mem_req_valid),
    .mem_req_is_store (mem_req_is_store),
    .mem_req_addr     (mem_req_addr),
    .mem_req_data     (mem_req_data),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Backing memory and architectural image, keyed by line address
  logic [127:0] bmem [logic [31:0]];
  logic [127:0] arch [logic [31:0]];

  // Results of the last do_req
  logic        last_hit, last_xcpt;
  int          n_wb, n_fill;
  logic [31:0] last_wb_addr, last_fill_addr, last_rsp;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] init_line(logic [31:0] la);
    return {la ^ 32'h3333_000C, la ^ 32'h2222_0008, la ^ 32'h1111_0004, la ^ 32'h0000_5A00};
  endfunction

  function automatic logic [127:0] bmem_get(logic [31:0] la);
    if (bmem.exists(la)) return bmem[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] arch_get(logic [31:0] la);
    if (arch.exists(la)) return arch[la];
    return bmem_get(la);
  endfunction

  // Applies one access to the architectural image; returns the expected rsp_data
  function automatic logic [31:0] model_access(logic [31:0] a, logic st, logic sz,
                                               logic [31:0] d);
    logic [31:0]  la;
    logic [127:0] ln;
    int           wo, bo;
    la = {a[31:4], 4'h0};
    ln = arch_get(la);
    wo = int'(a[3:2]);
    bo = int'(a[3:0]);
    if (st) begin
      if (sz) ln[wo*32 +: 32] = d;
      else    ln[bo*8 +: 8]   = d[7:0];
      arch[la] = ln;
      return 32'h0;
    end
    if (sz) return ln[wo*32 +: 32];
    return {24'h0, ln[bo*8 +: 8]};
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    arch.delete();
  endtask

  // One request, serviced through to completion with random memory latency
  task automatic do_req(input logic [31:0] a, input logic st, input logic sz, input logic [31:0] d);
    logic [31:0]  exp_d;
    logic         mis;
    bit           done;
    int           cyc;
    int           lat;
    logic [31:0]  maddr;
    logic         mst;
    logic [127:0] mdata;
    last_hit = 1'b0; last_xcpt = 1'b0; n_wb = 0; n_fill = 0;
    last_wb_addr = '0; last_fill_addr = '0; last_rsp = '0;
`ifdef DCACHE_ALIGN_CHECK_EN
    mis = sz && (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    exp_d = mis ? 32'h0 : model_access(a, st, sz, d);
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = a; req_is_store = st; req_size = sz; req_data = d;
    @(negedge clock);
    check_eq("accept_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check_eq("xcpt", xcpt_addr_fault, mis);
    if (mis) begin
      last_xcpt = xcpt_addr_fault;
      check_eq("xcpt_rsp", rsp_valid, 1'b0);
      check_eq("xcpt_mreq", mem_req_valid, 1'b0);
      return;
    end
    if (rsp_valid) begin
      last_hit = 1'b1;
      last_rsp = rsp_data;
      check_eq("hit_data", rsp_data, exp_d);
      return;
    end
    check_eq("miss_ready_low", req_ready, 1'b0);
    done = 0;
    cyc  = 0;
    while (!done && cyc < 64) begin
      cyc++;
      check_eq("mreq_valid", mem_req_valid, 1'b1);
      if (!mem_req_valid) break;
      maddr = mem_req_addr;
      mst   = mem_req_is_store;
      mdata = mem_req_data;
      check_eq("mreq_align", maddr[3:0], 4'h0);
      if (mst) begin
        n_wb++;
        last_wb_addr = maddr;
        check_eq("wb_data", mdata, arch_get(maddr));
      end else begin
        n_fill++;
        last_fill_addr = maddr;
      end
      lat = $urandom_range(0, 2);
      repeat (lat) begin
        @(negedge clock);
        check_eq("mreq_hold", {mem_req_valid, mem_req_is_store, mem_req_addr}, {1'b1, mst, maddr});
      end
      @(posedge clock); #1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mst ? {$urandom, $urandom, $urandom, $urandom} : bmem_get(maddr);
      if (mst) bmem[maddr] = mdata;
      @(posedge clock); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clock);
      if (mst) begin
        check_eq("fill_after_wb", {mem_req_valid, mem_req_is_store}, 2'b10);
      end else begin
        check_eq("replay_quiet", {rsp_valid, req_ready, mem_req_valid}, 3'b000);
        @(negedge clock);
        check_eq("replay_rsp", {rsp_valid, req_ready}, 2'b11);
        last_rsp = rsp_data;
        check_eq("miss_data", rsp_data, exp_d);
        done = 1;
      end
    end
    check_eq("miss_done", done, 1'b1);
  endtask

  logic [31:0] b_exp [10];
  logic [31:0] ra, rd;
  logic        rst_b, rsz;

  initial begin
    bmem[32'h100] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_outs", {rsp_valid, xcpt_addr_fault, mem_req_valid, mem_req_is_store}, 4'h0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_mreq_addr", mem_req_addr, 32'h0);
    check_eq("rst_mreq_data", mem_req_data, 128'h0);

    // Clean miss then hit in the same line
    do_req(32'h100, 1'b0, 1'b1, 32'h0);
    check_eq("t1_fill_cnt", {n_fill[3:0], n_wb[3:0]}, 8'h10);
    check_eq("t1_fill_addr", last_fill_addr, 32'h100);
    check_eq("t1_data", last_rsp, 32'hAAAAAAAA);
    do_req(32'h104, 1'b0, 1'b1, 32'h0);
    check_eq("t1_hit", last_hit, 1'b1);
    check_eq("t1_hit_data", last_rsp, 32'hBBBBBBBB);

    // Back-to-back hits: byte store then word load, then 8 more random hits
    @(posedge clock); #1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        ra = 32'h102; rst_b = 1'b1; rsz = 1'b0; rd = 32'h5A;
      end else if (i == 1) begin
        ra = 32'h100; rst_b = 1'b0; rsz = 1'b1; rd = 32'h0;
      end else begin
        ra = 32'h100 + $urandom_range(0, 15);
        rst_b = 1'($urandom_range(0, 1));
        rsz = 1'($urandom_range(0, 1));
        if (rsz) ra[1:0] = 2'b00;
        rd = $urandom;
      end
      req_valid = 1'b1; req_addr = ra; req_is_store = rst_b; req_size = rsz; req_data = rd;
      b_exp[i] = model_access(ra, rst_b, rsz, rd);
      @(negedge clock);
      check_eq("burst_ready", req_ready, 1'b1);
      if (i > 0) begin
        check_eq("burst_rsp_valid", rsp_valid, 1'b1);
        check_eq("burst_rsp_data", rsp_data, b_exp[i-1]);
      end
      if (i == 2) check_eq("store_then_load", rsp_data, 32'hAA5AAAAA);
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    @(negedge clock);
    check_eq("burst_last_valid", rsp_valid, 1'b1);
    check_eq("burst_last_data", rsp_data, b_exp[9]);

    // Conflict misses in set 0: round-robin victim with dirty write-back
    do_req(32'h140, 1'b1, 1'b1, 32'h1234_5678);
    check_eq("t3_clean_fill", {n_fill[3:0], n_wb[3:0]}, 8'h10);
    check_eq("t3_fill140", last_fill_addr, 32'h140);
    do_req(32'h180, 1'b0, 1'b1, 32'h0);
    check_eq("t3_evict_cnt", {n_fill[3:0], n_wb[3:0]}, 8'h11);
    check_eq("t3_wb_addr", last_wb_addr, 32'h100);
    check_eq("t3_fill_addr", last_fill_addr, 32'h180);
    do_req(32'h1C0, 1'b0, 1'b1, 32'h0);
    check_eq("t3_wb2_addr", last_wb_addr, 32'h140);

    // Misaligned word load
    do_req(32'h101, 1'b0, 1'b1, 32'h0);
`ifdef DCACHE_ALIGN_CHECK_EN
    check_eq("mis_xcpt", last_xcpt, 1'b1);
    @(negedge clock);
    check_eq("mis_quiet", {rsp_valid, xcpt_addr_fault, mem_req_valid, req_ready}, 4'b0001);
`else
    check_eq("mis_aligned_down", last_rsp, arch_get(32'h100) & 128'hFFFFFFFF);
`endif

    // Reset while filling drops the request
    @(posedge clock); #1;
    req_valid = 1'b1; req_addr = 32'h200; req_is_store = 1'b0; req_size = 1'b1;
    @(negedge clock);
    check_eq("rf_accept", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock);
    check_eq("rf_fill_state", {mem_req_valid, mem_req_is_store}, 2'b10);
    check_eq("rf_fill_addr", mem_req_addr, 32'h200);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    arch.delete();
    @(negedge clock);
    check_eq("rf_after_rst", {mem_req_valid, req_ready, rsp_valid}, 3'b010);
    @(negedge clock);
    check_eq("rf_no_rsp", rsp_valid, 1'b0);
    do_req(32'h200, 1'b0, 1'b1, 32'h0);
    check_eq("rf_reload_miss", {last_hit, n_fill[3:0]}, 5'h01);
    check_eq("rf_reload_addr", last_fill_addr, 32'h200);

    // Random traffic against the architectural image
    for (int i = 0; i < 300; i++) begin
      ra    = 32'($urandom_range(0, 511));
      rst_b = ($urandom_range(0, 99) < 40);
      rsz   = 1'($urandom_range(0, 1));
      if (rsz) ra[1:0] = 2'b00;
      rd    = $urandom;
      do_req(ra, rst_b, rsz, rd);
      if (i == 150) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
